demux_frame: RTL and testbench

//   Receive-side counterpart of the 2:1 stream mux. Takes a single valid/ready

---
 rtl/demux_frame.sv | 140 ++++++++++++++
 tb/tb_demux_frame.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_frame.sv
// Frame demultiplexer: routes whole FRAME_LEN-beat frames from one valid/ready
// stream to one of two registered single-entry output channels.

module demux_frame_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load wins over drain so a full buffer can sustain one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

module demux_frame #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_1_valid,
  output logic [WIDTH-1:0] out_1_data,
  input  logic             out_1_ready,
  output logic             out_2_valid,
  output logic [WIDTH-1:0] out_2_data,
  input  logic             out_2_ready,
  output logic             frame_done
);

  localparam int NUM_CH = 2;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic        chan, chan_d;
  logic        done_d;
  logic        tgt;
  logic        accept;

  // Channel index 1 is out_1 (sel=1), index 0 is out_2 (sel=0).
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH-1:0]            ch_load;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;

  assign ch_ready = {out_1_ready, out_2_ready};

  assign tgt      = (state == IDLE) ? sel : chan;
  assign in_ready = ~rst & (~ch_valid[tgt] | ch_ready[tgt]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    chan_d  = chan;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          chan_d = sel;
          if (FRAME_LEN == 1) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          if (cnt == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      chan       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      chan       <= chan_d;
      frame_done <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_load[g] = accept & (tgt == 1'(g));

    demux_frame_buf #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (ch_load[g]),
      .load_data (in_data),
      .ready     (ch_ready[g]),
      .valid     (ch_valid[g]),
      .data      (ch_data[g])
    );
  end

  assign out_1_valid = ch_valid[1];
  assign out_1_data  = ch_data[1];
  assign out_2_valid = ch_valid[0];
  assign out_2_data  = ch_data[0];

endmodule

// File: tb/tb_demux_frame.sv
// Scoreboard bench for demux_frame: FRAME_LEN=4 instance for most scenarios,
// FRAME_LEN=1 instance for the per-beat frame case.

module tb_demux_frame;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, sel, in_valid, out_1_ready, out_2_ready;
  logic [W-1:0] in_data;

  logic a_rdy, a_o1v, a_o2v, a_done;
  logic [W-1:0] a_o1d, a_o2d;
  logic b_rdy, b_o1v, b_o2v, b_done;
  logic [W-1:0] b_o1d, b_o2d;

  logic mode;  // 1 selects the FRAME_LEN=1 instance for observation
  logic m_rdy, m_o1v, m_o2v, m_done;
  logic [W-1:0] m_o1d, m_o2d;

  int total = 0, bad = 0, done_cnt = 0, stalls = 0, cyc = 0;
  logic [W-1:0] q1[$], q2[$];

  always #5 clk = ~clk;

  demux_frame #(.WIDTH(W), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_rdy), .out_1_valid(a_o1v), .out_1_data(a_o1d), .out_1_ready(out_1_ready),
    .out_2_valid(a_o2v), .out_2_data(a_o2d), .out_2_ready(out_2_ready), .frame_done(a_done));

  demux_frame #(.WIDTH(W), .FRAME_LEN(1)) dut_f1 (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_rdy), .out_1_valid(b_o1v), .out_1_data(b_o1d), .out_1_ready(out_1_ready),
    .out_2_valid(b_o2v), .out_2_data(b_o2d), .out_2_ready(out_2_ready), .frame_done(b_done));

  assign m_rdy  = mode ? b_rdy  : a_rdy;
  assign m_o1v  = mode ? b_o1v  : a_o1v;
  assign m_o1d  = mode ? b_o1d  : a_o1d;
  assign m_o2v  = mode ? b_o2v  : a_o2v;
  assign m_o2d  = mode ? b_o2d  : a_o2d;
  assign m_done = mode ? b_done : a_done;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: every drained beat is checked against the channel queue.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (m_done === 1'b1) done_cnt++;
        if (m_o1v === 1'b1 && out_1_ready === 1'b1) begin
          total++;
          if (q1.size() == 0) begin
            bad++;
            $display("FAIL out_1_unexpected got=%h expected=none", m_o1d);
          end else begin
            e = q1.pop_front();
            if (m_o1d !== e) begin
              bad++;
              $display("FAIL out_1_data got=%h expected=%h", m_o1d, e);
            end
          end
        end
        if (m_o2v === 1'b1 && out_2_ready === 1'b1) begin
          total++;
          if (q2.size() == 0) begin
            bad++;
            $display("FAIL out_2_unexpected got=%h expected=none", m_o2d);
          end else begin
            e = q2.pop_front();
            if (m_o2d !== e) begin
              bad++;
              $display("FAIL out_2_data got=%h expected=%h", m_o2d, e);
            end
          end
        end
      end
    end
  end

  // Drives one beat, waits (bounded) for acceptance, records its expected channel.
  // Returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic s, input int ch);
    int n;
    n = 0;
    sel = s; in_data = d; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (m_rdy === 1'b1) break;
      stalls++;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout data=%h in_ready=%b expected=1", d, m_rdy);
        break;
      end
    end
    if (n <= 50) begin
      if (ch == 1) q1.push_back(d);
      else q2.push_back(d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0;
    out_1_ready = 1'b1; out_2_ready = 1'b1; mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({m_o1v, m_o2v, m_done, m_rdy} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b expected=0000", {m_o1v, m_o2v, m_done, m_rdy});
    end
    total++;
    if (m_o1d !== '0 || m_o2d !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h expected=0000/0000", m_o1d, m_o2d);
    end
    rst = 1'b0; #1;
    total++;
    if (m_rdy !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got=%b expected=1", m_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      send_beat(W'(i + 1), 1'b1, 1);
      total++;
      if (m_o1v !== 1'b1 || m_o1d !== W'(i + 1)) begin
        bad++; $display("FAIL single_latency beat=%0d got=%b/%h expected=1/%h", i, m_o1v, m_o1d, W'(i + 1));
      end
      total++;
      if (m_done !== (i == 3)) begin
        bad++; $display("FAIL single_done beat=%0d got=%b expected=%b", i, m_done, (i == 3));
      end
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 != 1 || q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL single_summary done=%0d q1=%0d q2=%0d expected=1/0/0", done_cnt - d0, q1.size(), q2.size());
    end
  endtask

  task automatic test_sel_hold;
    logic [3:0] sels;
    sels = 4'b0001;  // beat 0 sel=1, later beats sel=0
    for (int i = 0; i < 4; i++) begin
      send_beat(W'(16'h0010 + i), sels[i], 1);
      total++;
      if (m_o1v !== 1'b1 || m_o1d !== W'(16'h0010 + i)) begin
        bad++; $display("FAIL sel_hold beat=%0d got=%b/%h expected=1/%h", i, m_o1v, m_o1d, W'(16'h0010 + i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_beat(W'(16'h0020 + i), 1'b0, 2);
      total++;
      if (m_o2v !== 1'b1 || m_o2d !== W'(16'h0020 + i)) begin
        bad++; $display("FAIL sel_zero beat=%0d got=%b/%h expected=1/%h", i, m_o2v, m_o2d, W'(16'h0020 + i));
      end
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL sel_drain q1=%0d q2=%0d expected=0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_backpressure;
    out_1_ready = 1'b0;
    send_beat(16'h00AA, 1'b1, 1);
    sel = 1'b1; in_data = 16'h00AB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (m_rdy !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b expected=0", i, m_rdy);
      end
      total++;
      if (m_o1v !== 1'b1 || m_o1d !== 16'h00AA) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h expected=1/00aa", i, m_o1v, m_o1d);
      end
    end
    @(posedge clk); #1;
    out_1_ready = 1'b1;
    send_beat(16'h00AB, 1'b1, 1);
    send_beat(16'h00AC, 1'b0, 1);
    send_beat(16'h00AD, 1'b0, 1);
    total++;
    if (m_done !== 1'b1) begin
      bad++; $display("FAIL bp_done got=%b expected=1", m_done);
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL bp_drain q1=%0d q2=%0d expected=0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_back_to_back;
    int d0, s0, c0;
    logic [2:0] fsel;
    fsel = 3'b101;
    d0 = done_cnt; s0 = stalls; c0 = cyc;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++)
        send_beat(W'(16'h0100 + f * 16 + i), fsel[f], fsel[f] ? 1 : 2);
    total++;
    if (cyc - c0 != 12 || stalls - s0 != 0) begin
      bad++; $display("FAIL b2b_rate cycles=%0d stalls=%0d expected=12/0", cyc - c0, stalls - s0);
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 != 3) begin
      bad++; $display("FAIL b2b_done got=%0d expected=3", done_cnt - d0);
    end
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL b2b_drain q1=%0d q2=%0d expected=0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    send_beat(16'h0030, 1'b1, 1);
    send_beat(16'h0031, 1'b1, 1);
    rst = 1'b1; #1;
    total++;
    if ({m_o1v, m_o2v, m_rdy} !== 3'b000 || m_o1d !== '0 || m_o2d !== '0) begin
      bad++; $display("FAIL midrst_clear got=%b %h/%h expected=000 0000/0000", {m_o1v, m_o2v, m_rdy}, m_o1d, m_o2d);
    end
    q1.delete(); q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(W'(16'h0040 + i), 1'b0, 2);
      total++;
      if (m_o2v !== 1'b1 || m_o2d !== W'(16'h0040 + i) || m_done !== (i == 3)) begin
        bad++; $display("FAIL midrst_frame beat=%0d got=%b/%h done=%b expected=1/%h done=%b",
                        i, m_o2v, m_o2d, m_done, W'(16'h0040 + i), (i == 3));
      end
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL midrst_drain q1=%0d q2=%0d expected=0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_frame_len_one;
    int d0;
    logic s;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mode = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0);
      send_beat(W'(16'h0050 + i), s, s ? 1 : 2);
      total++;
      if (m_done !== 1'b1) begin
        bad++; $display("FAIL fl1_done beat=%0d got=%b expected=1", i, m_done);
      end
      total++;
      if (s && (m_o1v !== 1'b1 || m_o1d !== W'(16'h0050 + i) || (i > 0 && m_o2v !== 1'b0)) ||
          !s && (m_o2v !== 1'b1 || m_o2d !== W'(16'h0050 + i) || m_o1v !== 1'b0)) begin
        bad++; $display("FAIL fl1_route beat=%0d got=v1:%b d1:%h v2:%b d2:%h expected data=%h on out_%0d",
                        i, m_o1v, m_o1d, m_o2v, m_o2d, W'(16'h0050 + i), s ? 1 : 2);
      end
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (done_cnt - d0 != 6 || q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL fl1_summary done=%0d q1=%0d q2=%0d expected=6/0/0", done_cnt - d0, q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_sel_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_len_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
